div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: start  in  1  divide request from execute stage; sampled only in IDLE.
REQ-006 Port: signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
REQ-007 Port: a  in  32  dividend; sampled with start.
REQ-008 Port: b  in  32  divisor; sampled with start.
REQ-009 Port: annul  in  1  pipeline flush or exception; cancels any operation.
REQ-010 Port: stall  out  1  freezes pipeline stages up to and including execute.
REQ-011 Port: busy  out  1  high in CALC and DONE.
REQ-012 Port: ready  out  1  one-cycle pulse; result valid, HI/LO write enable.
REQ-013 Port: hi  out  32  remainder; held until next ready.
REQ-014 Port: lo  out  32  quotient; held until next ready.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-016 IDLE, start=1, annul=0: latch |a|, |b|, sign(a), sign(b), signed_div; clear 5-bit iteration counter; go to CALC.
REQ-017 CALC: one restoring-division step per cycle, MSB first, producing one quotient bit; counter increments each cycle.
REQ-018 CALC: after the 32nd step (counter wraps 31->0), go to DONE.
REQ-019 DONE: ready=1 for exactly one cycle; hi/lo are registered on that edge; then go to IDLE.
REQ-020 Latency: start sampled at edge T SHALL give ready high in cycle T+33 (32 CALC cycles plus DONE).
REQ-021 Signed fix-up: quotient SHALL be negated when sign(a)!=sign(b); remainder SHALL take the sign of a.
REQ-022 Unsigned mode: no fix-up; operands are used as-is.
REQ-023 stall = (state==IDLE & start & ~annul) | (state==CALC).
REQ-024 stall SHALL be low in DONE, so the instruction advances in the same cycle ready is high.
REQ-025 start in CALC or DONE SHALL be ignored.
REQ-026 annul in any state SHALL force IDLE on the next edge, suppress ready, and leave hi/lo unchanged.
REQ-027 annul and start in the same IDLE cycle: start SHALL be ignored and stall SHALL be 0.
REQ-028 Divide by zero (default build): run the full 32 steps. Unsigned result: lo=0xFFFFFFFF, hi=a. Signed result: REQ-021 fix-up applied to the |a|/0 result.
REQ-029 0x80000000 / 0xFFFFFFFF, signed: lo=0x80000000, hi=0; no trap.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, counter=0, hi=0, lo=0, ready=0, stall=0, busy=0.
REQ-031 rst SHALL override start and annul, and SHALL abort CALC mid-operation with no ready pulse.

Configuration
REQ-032 Macro DIV_ZERO_FAST_EN defined: b==0 sampled at start SHALL go from IDLE directly to DONE, with hi=a and lo=0xFFFFFFFF in both signed and unsigned mode; ready is high at T+1 and stall is high only in the start cycle.
REQ-033 Macro DIV_ZERO_FAST_EN undefined: REQ-028 applies, with the full 33-cycle latency.

Verification
REQ-034 Unsigned 100/7 -> ready at T+33, lo=14, hi=2; stall high for cycles T..T+32.
REQ-035 Signed 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0 at T+33.
REQ-037 annul at T+10 -> state IDLE at T+11, no ready, hi/lo unchanged; new start at T+12 -> ready at T+45.
REQ-038 Unsigned 5/0 -> without macro, ready at T+33 with lo=0xFFFFFFFF, hi=5; with DIV_ZERO_FAST_EN, ready at T+1 with the same values.
REQ-039 rst at T+20 during CALC -> all outputs zero next cycle; no ready pulse within the following 40 cycles.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU): start at edge T gives ready in cycle T+33.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes in one cycle.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             ready_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             fast_zero;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (b == '0);
`else
    assign fast_zero = 1'b0;
`endif

    always_comb begin
        a_neg = signed_div & a[WIDTH-1];
        b_neg = signed_div & b[WIDTH-1];
        a_abs = a_neg ? ('0 - a) : a;
        b_abs = b_neg ? ('0 - b) : b;

        // The partial remainder stays below the divisor, so one extra bit holds the trial sign.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[WIDTH];
        rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], fits};

        lo_d = neg_quo_q ? ('0 - quo_d) : quo_d;
        hi_d = neg_rem_q ? ('0 - rem_d) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !annul) begin
                        if (fast_zero) begin
                            hi_q    <= a;
                            lo_q    <= '1;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= a_abs;
                            dvs_q     <= b_abs;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            cnt_q     <= '0;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        // Last step: commit the sign-corrected result straight into HI/LO.
                        if (cnt_q == 5'd31) begin
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall = ((state_q == IDLE) & start & ~annul) | (state_q == CALC);
    assign busy  = (state_q == CALC) | (state_q == DONE);
    assign ready = ready_q & ~annul;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall shape, signed/unsigned results, annul and reset.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall      (stall),
        .busy       (busy),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; the next edge is the start edge T.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat, input bit inject);
        int k;
        int stalls;
        signed_div = sd;
        a          = av;
        b          = bv;
        start      = 1'b1;
        annul      = 1'b0;
        #1;
        check({tag, "_stall_start"}, stall, 1'b1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0000_0003;
        k      = 1;
        stalls = 0;
        while (ready !== 1'b1 && k < 80) begin
            if (stall === 1'b1) stalls++;
            start = (inject && k == 5);
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_stall_cycles"}, stalls, exp_lat - 1);
        check({tag, "_stall_done"}, stall, 1'b0);
        check({tag, "_busy_done"}, busy, 1'b1);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, ready, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int n_ready;
        int zero_lat;
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_ready", ready, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 1'b0);
        run_op("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);
        run_op("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1'b0);
        run_op("u_ign_start", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 33, 1'b1);
`ifdef DIV_ZERO_FAST_EN
        zero_lat = 1;
`else
        zero_lat = 33;
`endif
        run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, zero_lat, 1'b0);

        // annul at T+10: back in IDLE at T+11, no ready, results held; restart at T+12.
        signed_div = 1'b0;
        a          = 32'd50;
        b          = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        n_ready = 0;
        repeat (9) begin
            if (ready === 1'b1) n_ready++;
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        if (ready === 1'b1) n_ready++;
        check("annul_busy", busy, 1'b0);
        check("annul_stall", stall, 1'b0);
        check("annul_no_ready", n_ready, 0);
        check("annul_hi_kept", hi, 32'd5);
        check("annul_lo_kept", lo, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        run_op("after_annul", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 33, 1'b0);

        // annul together with start in IDLE: request is dropped.
        a     = 32'd9;
        b     = 32'd2;
        start = 1'b1;
        annul = 1'b1;
        #1;
        check("annul_start_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        check("annul_start_busy", busy, 1'b0);
        check("annul_start_lo", lo, 32'd16);

        // Reset in the middle of CALC.
        a     = 32'd77;
        b     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_ready", ready, 1'b0);
        n_ready = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) n_ready++;
        end
        check("midrst_no_ready", n_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
